// File: rtl/vga_line_fetch.sv
// VGA line fetcher: pulls one 256-byte framebuffer row per hblank into a
// local line buffer and emits 2x-scaled, centred colour with a border.
module vga_line_fetch #(
   parameter logic [9:0]  WIN_X0       = 10'd64,
   parameter logic [9:0]  WIN_Y0       = 10'd48,
   parameter logic [7:0]  BORDER_COLOR = 8'h00,
   parameter logic [15:0] FB_BASE      = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pixel_en,
   input  logic [9:0]  counter_x,
   input  logic [9:0]  counter_y,
   output logic        mem_req,
   output logic [15:0] mem_addr,
   input  logic        mem_gnt,
   input  logic [7:0]  mem_data,
   output logic [7:0]  rgb,
   output logic        fetch_busy,
   output logic        underrun,
   input  logic        underrun_clr
);

   localparam logic [9:0] H_VIS  = 10'd640;
   localparam logic [9:0] V_VIS  = 10'd480;
   localparam logic [9:0] Y_LAST = 10'd524;
   localparam logic [9:0] X_END  = WIN_X0 + 10'd512;
   localparam logic [9:0] Y_END  = WIN_Y0 + 10'd384;

   typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

   state_t      state_q;
   logic [7:0]  idx_q;
   logic [7:0]  row_q;
   logic        mem_req_q;
   logic [15:0] mem_addr_q;
   logic        fetch_busy_q;
   logic        cap_vld_q;
   logic [7:0]  cap_idx_q;
   logic        underrun_q;
   logic [7:0]  rgb_q;
   logic [7:0]  rgb_d;

   logic [7:0]  linebuf [256];

   logic [9:0]  next_y;
   logic        trig;
   logic [7:0]  trig_row;
   logic        abort;
   logic        in_win;
   logic [7:0]  rd_idx;

   // Fetch trigger on the start of hblank for even window lines only;
   // odd window lines re-display the row already in the buffer.
   always_comb begin
      next_y   = (counter_y == Y_LAST) ? 10'd0 : counter_y + 10'd1;
      trig_row = 8'((next_y - WIN_Y0) >> 1);
      trig     = pixel_en && (counter_x == H_VIS) &&
                 (next_y >= WIN_Y0) && (next_y < Y_END) &&
                 !(next_y[0] ^ WIN_Y0[0]);
      abort    = pixel_en && (counter_x == WIN_X0) && (state_q != IDLE);
   end

   // Fetch FSM: one request per grant, last capture in DRAIN, abort when
   // the beam reaches the window before the row is complete.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         idx_q        <= 8'd0;
         row_q        <= 8'd0;
         mem_req_q    <= 1'b0;
         mem_addr_q   <= FB_BASE;
         fetch_busy_q <= 1'b0;
         cap_vld_q    <= 1'b0;
         cap_idx_q    <= 8'd0;
      end else begin
         cap_vld_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (trig) begin
                  state_q      <= REQ;
                  idx_q        <= 8'd0;
                  row_q        <= trig_row;
                  mem_req_q    <= 1'b1;
                  mem_addr_q   <= FB_BASE + {trig_row, 8'h00};
                  fetch_busy_q <= 1'b1;
               end
            end
            REQ: begin
               if (abort) begin
                  state_q      <= IDLE;
                  mem_req_q    <= 1'b0;
                  fetch_busy_q <= 1'b0;
               end else if (mem_gnt) begin
                  cap_vld_q <= 1'b1;
                  cap_idx_q <= idx_q;
                  if (idx_q == 8'hFF) begin
                     state_q   <= DRAIN;
                     mem_req_q <= 1'b0;
                  end else begin
                     idx_q      <= idx_q + 8'd1;
                     mem_addr_q <= FB_BASE + {row_q, idx_q + 8'd1};
                  end
               end
            end
            DRAIN: begin
               // The final capture (granted last clk) lands this clk either way.
               state_q      <= IDLE;
               fetch_busy_q <= 1'b0;
            end
            default: begin
               state_q      <= IDLE;
               mem_req_q    <= 1'b0;
               fetch_busy_q <= 1'b0;
            end
         endcase
      end
   end

   // Sticky underrun flag; a new underrun beats a simultaneous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)            underrun_q <= 1'b0;
      else if (abort)        underrun_q <= 1'b1;
      else if (underrun_clr) underrun_q <= 1'b0;
   end

   // Line buffer write, one clk after each accepted request.
   always_ff @(posedge clk) begin
      if (cap_vld_q) linebuf[cap_idx_q] <= mem_data;
   end

   // Colour select: blanking, scaled picture, or border.
   always_comb begin
      rd_idx = 8'((counter_x - WIN_X0) >> 1);
      in_win = (counter_x >= WIN_X0) && (counter_x < X_END) &&
               (counter_y >= WIN_Y0) && (counter_y < Y_END);
      rgb_d  = BORDER_COLOR;
      if ((counter_x >= H_VIS) || (counter_y >= V_VIS)) rgb_d = 8'h00;
      else if (in_win)                                   rgb_d = linebuf[rd_idx];
   end

   // Registered colour, advanced only on pixel strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        rgb_q <= 8'h00;
      else if (pixel_en) rgb_q <= rgb_d;
   end

   assign mem_req    = mem_req_q;
   assign mem_addr   = mem_addr_q;
   assign fetch_busy = fetch_busy_q;
   assign underrun   = underrun_q;
   assign rgb        = rgb_q;

endmodule

// File: tb/tb_vga_line_fetch.sv
// Directed bench for vga_line_fetch: row fetches, reuse, border/blank,
// grant stalls, underrun and async reset.
module tb_vga_line_fetch;

   localparam logic [7:0] BORDER = 8'hA5;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pixel_en = 1'b0;
   logic [9:0]  counter_x = 10'd0;
   logic [9:0]  counter_y = 10'd0;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_gnt = 1'b1;
   logic [7:0]  mem_data = 8'h00;
   logic [7:0]  rgb;
   logic        fetch_busy;
   logic        underrun;
   logic        underrun_clr = 1'b0;

   int          ncmp = 0;
   int          nerr = 0;
   int          nreq = 0;
   int          nbusy = 0;
   int          ncyc = 0;
   int          gnt_mode = 0;      // 0: always, 1: every 3rd clk, 2: never
   logic [15:0] exp_addr = 16'h0000;
   logic        hold_v = 1'b0;
   logic [15:0] hold_a = 16'h0000;
   logic [7:0]  exp_buf [256];

   vga_line_fetch #(.BORDER_COLOR(BORDER)) dut (
      .clk(clk), .rst_n(rst_n), .pixel_en(pixel_en),
      .counter_x(counter_x), .counter_y(counter_y),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
      .mem_data(mem_data), .rgb(rgb), .fetch_busy(fetch_busy),
      .underrun(underrun), .underrun_clr(underrun_clr)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      ncmp++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h (x=%0d y=%0d t=%0t)",
                  tag, got, exp, counter_x, counter_y, $time);
      end
   endtask

   // One clk: sample at negedge (grant, address, busy), then drive memory
   // read data and the next grant just after the rising edge.
   task automatic cyc();
      logic        g;
      logic [15:0] a;
      @(negedge clk);
      g = mem_req && mem_gnt;
      a = mem_addr;
      if (g) begin
         nreq++;
         chk("req_addr", 32'(mem_addr), 32'(exp_addr));
         exp_addr = exp_addr + 16'd1;
      end
      if (hold_v && mem_req) chk("addr_hold", 32'(mem_addr), 32'(hold_a));
      hold_v = mem_req && !mem_gnt;
      hold_a = mem_addr;
      if (fetch_busy) nbusy++;
      @(posedge clk);
      #1;
      mem_data = g ? (a[7:0] ^ a[15:8]) : 8'h00;
      ncyc++;
      case (gnt_mode)
         0:       mem_gnt = 1'b1;
         1:       mem_gnt = (ncyc % 3 == 0);
         default: mem_gnt = 1'b0;
      endcase
   endtask

   task automatic pix(int x, int y);
      counter_x = 10'(x);
      counter_y = 10'(y);
      pixel_en  = 1'b1;
      cyc();
      pixel_en  = 1'b0;
   endtask

   function automatic logic [7:0] exp_rgb(int x, int y);
      if (x >= 640 || y >= 480)                      return 8'h00;
      if (x >= 64 && x < 576 && y >= 48 && y < 432)  return exp_buf[(x - 64) / 2];
      return BORDER;
   endfunction

   task automatic run_line(int y, int x0, int x1, bit do_chk);
      for (int x = x0; x <= x1; x++) begin
         pix(x, y);
         if (do_chk) chk("rgb", 32'(rgb), 32'(exp_rgb(x, y)));
         cyc(); cyc(); cyc();
      end
   endtask

   task automatic load_row(int r);
      for (int i = 0; i < 256; i++) exp_buf[i] = 8'(i) ^ 8'(r);
   endtask

   initial begin
      // Reset with grant held high
      for (int i = 0; i < 4; i++) cyc();
      chk("rst_rgb", 32'(rgb), 32'h0);
      chk("rst_req", 32'(mem_req), 32'h0);
      chk("rst_busy", 32'(fetch_busy), 32'h0);
      chk("rst_unr", 32'(underrun), 32'h0);
      chk("rst_addr", 32'(mem_addr), 32'h0);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) cyc();
      chk("post_rst_rgb", 32'(rgb), 32'h0);
      chk("post_rst_req", 32'(mem_req), 32'h0);
      chk("post_rst_nreq", 32'(nreq), 32'h0);

      // Full fetch of row 0 during line 47's hblank
      nreq = 0; nbusy = 0; exp_addr = 16'h0000;
      run_line(47, 640, 799, 0);
      chk("row0_nreq", 32'(nreq), 32'd256);
      chk("row0_busy", 32'(nbusy), 32'd257);
      chk("row0_unr", 32'(underrun), 32'h0);
      load_row(0);

      // Line 48 displays row 0; its hblank must not fetch
      nreq = 0; nbusy = 0;
      run_line(48, 0, 799, 1);
      chk("reuse_nreq", 32'(nreq), 32'd0);
      chk("reuse_busy", 32'(nbusy), 32'd0);

      // Line 49 reuses row 0; row 1 fetched with grants every 3rd clk
      gnt_mode = 1;
      nreq = 0; exp_addr = 16'h0100;
      run_line(49, 0, 799, 1);
      load_row(1);
      run_line(50, 0, 799, 1);
      chk("row1_nreq", 32'(nreq), 32'd256);
      chk("stall_unr", 32'(underrun), 32'h0);
      run_line(51, 60, 100, 1);

      // Border and blanking corners
      pix(100, 479); chk("y479_border", 32'(rgb), 32'(BORDER)); cyc();
      pix(100, 500); chk("y500_blank", 32'(rgb), 32'h0); cyc();
      pix(63, 48);   chk("x63_border", 32'(rgb), 32'(BORDER)); cyc();
      pix(576, 48);  chk("x576_border", 32'(rgb), 32'(BORDER)); cyc();

      // Underrun: no grants during line 47 hblank
      gnt_mode = 2;
      run_line(47, 640, 799, 0);
      run_line(48, 0, 63, 0);
      chk("pre_unr_req", 32'(mem_req), 32'h1);
      chk("pre_unr_flag", 32'(underrun), 32'h0);
      pix(64, 48);
      chk("unr_flag", 32'(underrun), 32'h1);
      chk("unr_req", 32'(mem_req), 32'h0);
      chk("unr_busy", 32'(fetch_busy), 32'h0);
      for (int i = 0; i < 5; i++) cyc();
      chk("unr_sticky", 32'(underrun), 32'h1);
      underrun_clr = 1'b1;
      cyc();
      underrun_clr = 1'b0;
      chk("unr_clr", 32'(underrun), 32'h0);

      // Async reset mid-fetch
      gnt_mode = 1;
      exp_addr = 16'h0000;
      run_line(47, 640, 650, 0);
      chk("mid_req", 32'(mem_req), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_req", 32'(mem_req), 32'h0);
      chk("async_busy", 32'(fetch_busy), 32'h0);
      cyc(); cyc();
      rst_n = 1'b1;
      chk("async_rgb", 32'(rgb), 32'h0);

      // Clean restart from index 0 after reset
      gnt_mode = 0;
      nreq = 0; nbusy = 0; exp_addr = 16'h0000;
      run_line(47, 640, 799, 0);
      chk("restart_nreq", 32'(nreq), 32'd256);
      chk("restart_busy", 32'(nbusy), 32'd257);
      load_row(0);
      run_line(48, 0, 639, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
